sevseg_scan_ctrl: RTL and testbench
===================================

# sevseg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It shares one registered BCD→segment decoder across `NUM_DIGITS` digits. Each cycle of the scan it presents one digit's nibble to the decoder, drives that digit's active-low anode, and inserts an anti-ghosting blank interval between digits. It sits between the value source, such as a counter or register file, and the existing decoder plus the board anode pins.

## Interface

**Parameters**
- `NUM_DIGITS`, default 4: number of multiplexed digits, from 2 to 8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot, including blank cycles. Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all anodes off. Must be at least 1.

**Ports**
- `clk` (in, 1): single system clock; all state updates on the rising edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `enable` (in, 1): when high, the block scans; when low, it idles with the display dark.
- `load` (in, 1): single-cycle pulse that captures `value_in` and `dp_in` into the shadow register.
- `value_in` (in, 4·NUM_DIGITS): packed BCD; digit 0 is bits [3:0] and is the least significant digit.
- `dp_in` (in, NUM_DIGITS): per-digit decimal-point request; 1 means lit.
- `lzb` (in, 1): leading-zero blanking enable.
- `dig_code` (out, 4): nibble to the decoder; bit 0 drives decoder input A, bit 3 drives D.
- `an_n` (out, NUM_DIGITS): active-low anode enables.
- `dp_n` (out, 1): active-low decimal point.
- `frame_start` (out, 1): one-cycle pulse when digit 0's slot begins.

## Operation

**State machine: IDLE, BLANK, DRIVE**
- **IDLE:** `an_n` all 1, `dp_n` = 1, `idx` = 0.
  - When `enable` = 1, go to BLANK at `idx` 0 and perform a frame transfer.
- **BLANK:** lasts `BLANK_CYCLES` cycles. `dig_code` = `active[idx]`, all anodes off, then go to DRIVE.
- **DRIVE:** lasts `REFRESH_DIV − BLANK_CYCLES` cycles. `an_n[idx]` = 0 unless the digit is blanked; `dp_n` = ~`active_dp[idx]`.
  - At the end of the slot, go to BLANK with `idx`+1.
  - If `idx` = `NUM_DIGITS`−1, wrap to `idx` 0 and perform a frame transfer.
- **`enable` low:** in any state, go to IDLE on the next edge; anodes are off from that edge onward. The slot counter and `idx` clear.

**Double buffering**
- `load` writes the shadow copy and sets `pending`.
- A frame transfer copies shadow to active only when `pending` = 1, then clears `pending`. The displayed frame never tears.
- If `load` coincides with a frame transfer, the incoming `value_in`/`dp_in` go straight into active, and `pending` stays 0.
- A `load` in any other cycle overwrites the shadow; the last load wins.

**Leading-zero blanking**
- With `lzb` = 1, digit i (i ≥ 1) is blanked when `active[i]` and every higher digit are 0.
- Digit 0 is never blanked. A blanked digit keeps its anode off during DRIVE, and its DP is still shown.
- `lzb` is sampled per slot.

**Slot counter**
- Width is clog2(`REFRESH_DIV`). It counts 0 to `REFRESH_DIV`−1 and wraps at the slot boundary; no other wrap exists.

## Timing

**Reset values** (asserted asynchronously by `rst_n` low)
- `dig_code` = 0, `an_n` = all 1, `dp_n` = 1, `frame_start` = 0.
- state = IDLE, `idx` = 0, shadow/active/dp registers = 0, `pending` = 0.
- Reset mid-scan blanks the display immediately.

**Output registering**
- All outputs are registered.
- `dig_code` changes on the edge entering BLANK, so the decoder's registered segments settle one cycle later. `BLANK_CYCLES` ≥ 1 guarantees segments are valid before any anode turns on.
- `an_n` and `dp_n` change on the edge entering DRIVE and on the edge leaving DRIVE.

**Latency**
- From `enable` rising in IDLE, `frame_start` goes high 1 cycle later.
- The first anode goes low `BLANK_CYCLES`+1 cycles after `enable` rises.

**Period**
- Frame period = `NUM_DIGITS`·`REFRESH_DIV` cycles.

## Structure

- A shared package `sevseg_pkg` holds:
  - the digit-width constant (4);
  - the state enum {IDLE, BLANK, DRIVE};
  - a function computing the leading-zero blank mask from packed BCD.
- One sub-module, `scan_timer`, contains the slot counter and emits `blank_done` and `slot_done` strobes.
- The state machine, buffers, and output registers live in the top level.

## Test plan

Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.

1. **Basic scan.** Load 0x1234, then enable.
   - `dig_code` sequence is 4,3,2,1, each held for 8 cycles.
   - Each `an_n` is low for 6 cycles.
   - `frame_start` pulses every 32 cycles.
2. **Leading-zero blanking.** `lzb`=1, value 0x0070.
   - Digits 3 and 2 stay dark; digits 1 and 0 light.
   - With value 0x0000, only digit 0 lights.
3. **Load mid-frame.** Load 0x5555 during digit 2 of a 0x1234 frame.
   - The rest of the frame still shows 1234.
   - The next frame shows 5555.
4. **Load coincident with frame transfer.** Load on the same cycle as a frame transfer.
   - The new value is shown in the starting frame, and `pending` stays 0.
5. **Enable drop.** Deassert `enable` mid-DRIVE.
   - `an_n` is all 1 on the next edge.
   - On re-enable, the scan restarts at digit 0 with a 2-cycle blank.
6. **Asynchronous reset mid-scan.** Assert `rst_n` low between clock edges.
   - Outputs go to reset values without waiting for a clock edge.
   - After release, the display is dark until `enable` is high.

Source files
------------

// File: rtl/sevseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: digit width,
// scan state encoding and the leading-zero blank mask helper.
package sevseg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Bit i set means digit i is a leading zero (it and every higher digit are 0).
  // Digit 0 is never blanked, so bit 0 is always clear. Callers zero-extend
  // narrower frames; the extra zero digits do not change the lower bits.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] bcd
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (bcd[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/sevseg_scan_ctrl_if.sv
// Bus between the value source and the scan controller, plus the display
// pins and debug taps coming back.
//
// Handshake: load is a valid-only strobe. There is no ready; the controller
// accepts value_in/dp_in on every cycle load is high, and a later load before
// the next frame transfer simply replaces the earlier one.
interface sevseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import sevseg_pkg::*;

  logic                          enable;
  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic                          lzb;
  logic [DIGIT_W-1:0]            dig_code;
  logic [NUM_DIGITS-1:0]         an_n;
  logic                          dp_n;
  logic                          frame_start;
  state_t                        state_dbg;
  logic                          pending_dbg;

  modport master (
    output enable, load, value_in, dp_in, lzb,
    input  dig_code, an_n, dp_n, frame_start, state_dbg, pending_dbg
  );

  modport slave (
    input  enable, load, value_in, dp_in, lzb,
    output dig_code, an_n, dp_n, frame_start, state_dbg, pending_dbg
  );

endinterface

// File: rtl/sevseg_scan_ctrl_scan_timer.sv
// Slot counter for one digit slot: counts 0..REFRESH_DIV-1 and flags the last
// blank cycle and the last cycle of the slot.
module scan_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] count;

  assign blank_done = (count == CW'(BLANK_CYCLES - 1));
  assign slot_done  = (count == CW'(REFRESH_DIV - 1));

  // Free-running slot counter, held at zero while the scan is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || slot_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffers the incoming frame, walks the digits with a blank gap before
// each one, and drives the shared decoder nibble plus active-low anodes/DP.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic              clk,
  input logic              rst_n,
  sevseg_scan_ctrl_if.slave bus
);

  localparam int             IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t                               state_q, state_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   shadow_q, active_q, active_d;
  logic [NUM_DIGITS-1:0]                shadow_dp_q, active_dp_q, active_dp_d;
  logic                                 pending_q;
  logic [DIGIT_W-1:0]                   code_q, code_d;
  logic [NUM_DIGITS-1:0]                an_q, an_d;
  logic                                 dp_q, dp_d;
  logic                                 fs_q, fs_d;
  logic                                 xfer, enter_blank;
  logic                                 blank_done, slot_done, timer_clear;
  logic [NUM_DIGITS-1:0]                lz_mask, one_hot;

  // The counter stays at zero in IDLE so the first slot after enable starts clean.
  assign timer_clear = (state_q == IDLE) || !bus.enable;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  assign lz_mask = NUM_DIGITS'(lzb_mask((DIGIT_W*MAX_DIGITS)'(active_q)));
  assign one_hot = NUM_DIGITS'(1) << idx_q;

  // Next state, digit index and anode/DP/frame_start next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xfer        = 1'b0;
    enter_blank = 1'b0;
    fs_d        = 1'b0;
    an_d        = an_q;
    dp_d        = dp_q;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      an_d    = '1;
      dp_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = '0;
          xfer        = 1'b1;
          enter_blank = 1'b1;
          fs_d        = 1'b1;
        end
        BLANK: begin
          if (blank_done) begin
            state_d = DRIVE;
            an_d    = (bus.lzb && lz_mask[idx_q]) ? '1 : ~one_hot;
            dp_d    = ~active_dp_q[idx_q];
          end
        end
        DRIVE: begin
          if (slot_done) begin
            state_d     = BLANK;
            enter_blank = 1'b1;
            an_d        = '1;
            dp_d        = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              xfer  = 1'b1;
              fs_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          an_d    = '1;
          dp_d    = 1'b1;
        end
      endcase
    end
  end

  // Frame transfer: a load on the transfer cycle bypasses the shadow copy.
  always_comb begin
    active_d    = active_q;
    active_dp_d = active_dp_q;
    if (xfer && bus.load) begin
      active_d    = bus.value_in;
      active_dp_d = bus.dp_in;
    end else if (xfer && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
    end
  end

  // The decoder nibble changes only on the edge that enters BLANK.
  always_comb begin
    code_d = code_q;
    if (enter_blank) begin
      code_d = active_d[idx_d];
    end
  end

  // Scan state and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow/active frame buffers and the pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      if (bus.load && !xfer) begin
        shadow_q    <= bus.value_in;
        shadow_dp_q <= bus.dp_in;
        pending_q   <= 1'b1;
      end else if (xfer) begin
        pending_q   <= 1'b0;
      end
    end
  end

  // Registered display outputs; reset darkens the display at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      an_q   <= '1;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      code_q <= code_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.dig_code    = code_q;
  assign bus.an_n        = an_q;
  assign bus.dp_n        = dp_q;
  assign bus.frame_start = fs_q;
  assign bus.state_dbg   = state_q;
  assign bus.pending_dbg = pending_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against a time-based reference.
module tb_sevseg_scan_ctrl;
  import sevseg_pkg::*;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sevseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  sevseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outputs follow from time since the scan started.
  bit          m_run;
  int          m_t;
  logic [15:0] m_frame, m_shadow;
  logic [3:0]  m_fdp, m_sdp;
  logic        m_pending;
  logic        m_slot_lz;
  logic [3:0]  m_code;
  logic [3:0]  m_an;
  logic        m_dp;
  logic        m_fs;
  state_t      m_state;

  task automatic model_reset();
    m_run     = 1'b0;
    m_t       = 0;
    m_frame   = '0;
    m_shadow  = '0;
    m_fdp     = '0;
    m_sdp     = '0;
    m_pending = 1'b0;
    m_slot_lz = 1'b0;
    m_code    = '0;
    m_an      = 4'hF;
    m_dp      = 1'b1;
    m_fs      = 1'b0;
    m_state   = IDLE;
  endtask

  // Applied at each rising edge with the inputs present at that edge.
  task automatic model_update();
    int   phase;
    int   digit;
    logic xfer;
    if (!rst_n) begin
      model_reset();
      return;
    end
    xfer = 1'b0;
    if (!bus.enable) begin
      m_run   = 1'b0;
      m_an    = 4'hF;
      m_dp    = 1'b1;
      m_fs    = 1'b0;
      m_state = IDLE;
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = m_t + 1;
      end
      xfer = (m_t % FRAME == 0);
    end
    if (xfer && bus.load) begin
      m_frame   = bus.value_in;
      m_fdp     = bus.dp_in;
      m_pending = 1'b0;
    end else if (xfer && m_pending) begin
      m_frame   = m_shadow;
      m_fdp     = m_sdp;
      m_pending = 1'b0;
    end else if (bus.load) begin
      m_shadow  = bus.value_in;
      m_sdp     = bus.dp_in;
      m_pending = 1'b1;
    end
    if (bus.enable) begin
      phase = m_t % RD;
      digit = (m_t / RD) % ND;
      if (phase == BC) m_slot_lz = bus.lzb;
      m_fs   = (m_t % FRAME == 0);
      m_code = 4'((m_frame >> (4 * digit)) & 16'hF);
      if (phase >= BC) begin
        m_state = DRIVE;
        m_dp    = ~m_fdp[digit];
        if (m_slot_lz && digit >= 1 && (m_frame >> (4 * digit)) == 16'h0)
          m_an = 4'hF;
        else
          m_an = ~(4'b0001 << digit);
      end else begin
        m_state = BLANK;
        m_an    = 4'hF;
        m_dp    = 1'b1;
      end
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("dig_code",    32'(bus.dig_code),    32'(m_code));
    chk("an_n",        32'(bus.an_n),        32'(m_an));
    chk("dp_n",        32'(bus.dp_n),        32'(m_dp));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    chk("state",       32'(bus.state_dbg),   32'(m_state));
    chk("pending",     32'(bus.pending_dbg), 32'(m_pending));
  endtask

  // Driver tasks: inputs change at the falling edge, checks run there too.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    bus.load     = 1'b1;
    bus.value_in = v;
    bus.dp_in    = dp;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != target; i++) tick();
    chk("wait_t_reached", 32'(m_t % FRAME), 32'(target));
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int d = 0; d < ND; d++) begin
      if ($urandom_range(0, 2) != 0) v[d*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.lzb      = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state and dark display before enable
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic scan of 1234
    load_word(16'h1234, 4'b0100);
    bus.enable = 1'b1;
    tick();
    chk("start_code", 32'(bus.dig_code), 32'h4);
    chk("start_fs",   32'(bus.frame_start), 32'h1);
    repeat (BC - 1) tick();
    chk("blank_before_anode", 32'(bus.an_n), 32'hF);
    tick();
    chk("first_anode", 32'(bus.an_n), 32'hE);
    repeat (70) tick();

    // Leading-zero blanking
    bus.lzb = 1'b1;
    load_word(16'h0070, 4'b0000);
    repeat (2 * FRAME) tick();
    load_word(16'h0000, 4'b1000);
    repeat (2 * FRAME) tick();
    bus.lzb = 1'b0;

    // Load mid-frame during digit 2
    load_word(16'h1234, 4'b0001);
    wait_t(0);
    wait_t(17);
    load_word(16'h5555, 4'b0010);
    chk("midload_pending", 32'(bus.pending_dbg), 32'h1);
    repeat (FRAME + 16) tick();

    // Load coincident with frame transfer
    wait_t(FRAME - 1);
    load_word(16'h9876, 4'b1001);
    chk("coinc_pending", 32'(bus.pending_dbg), 32'h0);
    chk("coinc_code",    32'(bus.dig_code),    32'h6);
    repeat (FRAME + 8) tick();

    // Enable drop mid-DRIVE and restart
    wait_t(4);
    bus.enable = 1'b0;
    tick();
    chk("drop_an", 32'(bus.an_n), 32'hF);
    repeat (3) tick();
    bus.enable = 1'b1;
    tick();
    chk("restart_state", 32'(bus.state_dbg), 32'(BLANK));
    chk("restart_code",  32'(bus.dig_code),  32'h6);
    repeat (BC - 1) tick();
    chk("restart_blank", 32'(bus.an_n), 32'hF);
    tick();
    chk("restart_anode", 32'(bus.an_n), 32'hE);
    repeat (20) tick();

    // Asynchronous reset between edges
    wait_t(10);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_code",  32'(bus.dig_code),    32'h0);
    chk("areset_an",    32'(bus.an_n),        32'hF);
    chk("areset_dp",    32'(bus.dp_n),        32'h1);
    chk("areset_fs",    32'(bus.frame_start), 32'h0);
    chk("areset_state", 32'(bus.state_dbg),   32'(IDLE));
    model_reset();
    repeat (2) tick();
    rst_n      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) tick();
    bus.enable = 1'b1;
    repeat (40) tick();

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      bus.load = ($urandom_range(0, 11) == 0);
      if (bus.load) begin
        bus.value_in = rand_bcd();
        bus.dp_in    = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) bus.lzb = ~bus.lzb;
      bus.enable = ($urandom_range(0, 199) != 0);
      tick();
    end
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    repeat (FRAME) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
